// File: rtl/aq_gemac_pkg.sv
// Shared GEMAC definitions: class count limit, quanta width, legacy slot.
// No ports; imported by the pause flow controller files.
package aq_gemac_pkg;
  localparam int AQ_GEMAC_MAX_CLASS = 8;
  localparam int AQ_QUANTA_W = 16;
  localparam int LEGACY_SLOT = 0;
  typedef logic [AQ_QUANTA_W-1:0] quanta_t;
endpackage

// File: rtl/aq_gemac_pfc_timer.sv
// One class pause timer: clear > load > tick-decrement, registered apply.
// Ports: clk, rst_n, load, load_val, tick, clear, apply_en, apply (out).
module aq_gemac_pfc_timer
  import aq_gemac_pkg::*;
#(
  parameter int QW = AQ_QUANTA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [QW-1:0] load_val,
  input  logic          tick,
  input  logic          clear,
  input  logic          apply_en,
  output logic          apply
);

  logic [QW-1:0] cnt;
  logic [QW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (tick && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  // apply follows the new count so it rises right after the load edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      apply <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      apply <= (cnt_nxt != '0) & apply_en;
    end
  end

endmodule

// File: rtl/aq_gemac_pfc_ctrl.sv
// PFC / 802.3x pause controller: per-class timers, ack, mode-change clear.
// Ports: CLK, RST_N, PFC_MODE, TX_PAUSE_ENABLE, CLASS_ENABLE, PAUSE_QUANTA_VALID,
// PAUSE_CLASS_VEC, PAUSE_QUANTA, PAUSE_QUANTA_COMPLETE, PAUSE_QUANTA_SUB,
// PAUSE_APPLY, PAUSE_ANY, STAT_SEL, STAT_CLR, STAT_COUNT.
// Option macro AQ_GEMAC_PFC_STATS_EN adds per-class pause event counters.
module aq_gemac_pfc_ctrl
  import aq_gemac_pkg::*;
#(
  parameter int NUM_CLASS = AQ_GEMAC_MAX_CLASS,
  parameter int QUANTA_W  = AQ_QUANTA_W,
  parameter int STAT_W    = 16,
  localparam int SEL_W    = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          PFC_MODE,
  input  logic                          TX_PAUSE_ENABLE,
  input  logic [NUM_CLASS-1:0]          CLASS_ENABLE,
  input  logic                          PAUSE_QUANTA_VALID,
  input  logic [NUM_CLASS-1:0]          PAUSE_CLASS_VEC,
  input  logic [NUM_CLASS*QUANTA_W-1:0] PAUSE_QUANTA,
  output logic                          PAUSE_QUANTA_COMPLETE,
  input  logic                          PAUSE_QUANTA_SUB,
  output logic [NUM_CLASS-1:0]          PAUSE_APPLY,
  output logic                          PAUSE_ANY,
  input  logic [SEL_W-1:0]              STAT_SEL,
  input  logic                          STAT_CLR,
  output logic [STAT_W-1:0]             STAT_COUNT
);

  logic                mode_q;
  logic                mode_chg;
  logic                clr_all;
  logic [NUM_CLASS-1:0] load;
  logic [NUM_CLASS-1:0] cls_en;
  logic [QUANTA_W-1:0] ld_val [NUM_CLASS];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q                <= 1'b0;
      PAUSE_QUANTA_COMPLETE <= 1'b0;
    end else begin
      mode_q                <= PFC_MODE;
      PAUSE_QUANTA_COMPLETE <= PAUSE_QUANTA_VALID;
    end
  end

  assign mode_chg = PFC_MODE ^ mode_q;
  assign clr_all  = mode_chg | ~TX_PAUSE_ENABLE;

  genvar g;
  generate
    for (g = 0; g < NUM_CLASS; g++) begin : g_cls
      assign ld_val[g] = PFC_MODE
        ? PAUSE_QUANTA[g*QUANTA_W +: QUANTA_W]
        : PAUSE_QUANTA[LEGACY_SLOT*QUANTA_W +: QUANTA_W];
      assign load[g] = PAUSE_QUANTA_VALID & ~clr_all
        & (PAUSE_CLASS_VEC[g] | ~PFC_MODE);
      assign cls_en[g] = CLASS_ENABLE[g] | ~PFC_MODE;

      aq_gemac_pfc_timer #(
        .QW (QUANTA_W)
      ) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (load[g]),
        .load_val (ld_val[g]),
        .tick     (PAUSE_QUANTA_SUB),
        .clear    (clr_all),
        .apply_en (TX_PAUSE_ENABLE & cls_en[g]),
        .apply    (PAUSE_APPLY[g])
      );
    end
  endgenerate

  assign PAUSE_ANY = |PAUSE_APPLY;

`ifdef AQ_GEMAC_PFC_STATS_EN
  logic [STAT_W-1:0]    stat_q [NUM_CLASS];
  logic [NUM_CLASS-1:0] inc;

  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      inc[i] = load[i] & (ld_val[i] != '0) & cls_en[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CLASS; i++) stat_q[i] <= '0;
      STAT_COUNT <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (STAT_CLR) begin
          stat_q[i] <= '0;
        end else if (inc[i] && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + 1'b1;
        end
      end
      STAT_COUNT <= (int'(STAT_SEL) < NUM_CLASS)
        ? stat_q[STAT_SEL] : '0;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{STAT_SEL, STAT_CLR};
  assign STAT_COUNT  = '0;
`endif

endmodule
